// File: rtl/layer2_argmax.sv
// layer2_argmax: scans the Layer 2 logit store one entry per cycle and reports the argmax class.
// Define ARGMAX_MARGIN_EN to also track the runner-up and report top1-top2 on margin.
module layer2_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int LOGIT_W = 6,
  parameter int IDX_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [IDX_W-1:0]          logit_addr,
  input  logic signed [LOGIT_W-1:0] logit_data,
  output logic [IDX_W-1:0]          class_idx,
  output logic signed [LOGIT_W-1:0] max_logit,
  output logic                      class_valid,
  output logic [LOGIT_W:0]          margin
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE_ST} state_t;
  localparam logic signed [LOGIT_W-1:0] MIN_VAL = {1'b1, {(LOGIT_W-1){1'b0}}};
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);
  state_t state;
  logic signed [LOGIT_W-1:0] best_val, nb_val;
  logic [IDX_W-1:0] best_idx, nb_idx;
  logic gt_best;
  logic [LOGIT_W:0] nm;
  // Strict compare keeps the lowest index on ties.
  always_comb begin
    gt_best = logit_data > best_val;
    nb_val = gt_best ? logit_data : best_val;
    nb_idx = gt_best ? logit_addr : best_idx;
  end
`ifdef ARGMAX_MARGIN_EN
  logic signed [LOGIT_W-1:0] second_val, ns_val;
  always_comb begin
    ns_val = gt_best ? best_val : (logit_data > second_val ? logit_data : second_val);
    nm = {nb_val[LOGIT_W-1], nb_val} - {ns_val[LOGIT_W-1], ns_val};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) second_val <= MIN_VAL;
    else if (state == IDLE && start) second_val <= MIN_VAL;
    else if (state == SCAN) second_val <= ns_val;
`else
  assign nm = '0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      class_valid <= 1'b0;
      class_idx <= '0;
      max_logit <= '0;
      margin <= '0;
      logit_addr <= '0;
      best_val <= MIN_VAL;
      best_idx <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= SCAN;
          busy <= 1'b1;
          logit_addr <= '0;
          class_valid <= 1'b0;
          best_val <= MIN_VAL;
          best_idx <= '0;
        end
        SCAN: begin
          best_val <= nb_val;
          best_idx <= nb_idx;
          if (logit_addr == LAST) begin
            class_idx <= nb_idx;
            max_logit <= nb_val;
            margin <= nm;
            class_valid <= 1'b1;
            done <= 1'b1;
            busy <= 1'b0;
            state <= DONE_ST;
          end else logit_addr <= logit_addr + 1'b1;
        end
        DONE_ST: if (!start) begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer2_argmax.sv
// tb_layer2_argmax: directed argmax vectors and handshake/reset checks against hand-computed results.
module tb_layer2_argmax;
  logic clk = 0, rst_n = 0, start = 0;
  logic busy, done, class_valid;
  logic [3:0] logit_addr, class_idx;
  logic signed [5:0] logit_data, max_logit;
  logic [6:0] margin;
  logic signed [5:0] logits [10];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  assign logit_data = (logit_addr < 4'd10) ? logits[logit_addr] : 6'sd0;
  layer2_argmax dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .logit_addr(logit_addr), .logit_data(logit_data), .class_idx(class_idx),
    .max_logit(max_logit), .class_valid(class_valid), .margin(margin)
  );
  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int exp_margin(input int m);
`ifdef ARGMAX_MARGIN_EN
    return m;
`else
    return 0 * m;
`endif
  endfunction
  // Counts edges from driving start until done; busy is counted per cycle.
  task automatic run(input string tag, input int ei, input int em, input int eg);
    int n = 0, b = 0;
    @(negedge clk);
    start = 1;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
      if (busy) b++;
    end
    check({tag, " latency"}, n, 11);
    check({tag, " busy_cycles"}, b, 10);
    check({tag, " class_idx"}, class_idx, ei);
    check({tag, " max_logit"}, max_logit, em);
    check({tag, " margin"}, margin, exp_margin(eg));
    check({tag, " class_valid"}, class_valid, 1);
    check({tag, " addr_last"}, logit_addr, 9);
    repeat (3) @(negedge clk);
    check({tag, " held_done"}, done, 1);
    check({tag, " no_restart"}, busy, 0);
    start = 0;
    @(negedge clk);
    check({tag, " idle_done"}, done, 0);
    check({tag, " idle_valid"}, class_valid, 1);
    check({tag, " idle_idx"}, class_idx, ei);
  endtask
  initial begin
    #12;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst valid", class_valid, 0);
    check("rst idx", class_idx, 0);
    check("rst max", max_logit, 0);
    check("rst margin", margin, 0);
    check("rst addr", logit_addr, 0);
    rst_n = 1;
    logits = '{-6'sd3, 6'sd5, 6'sd1, -6'sd32, 6'sd2, 6'sd0, 6'sd4, -6'sd1, 6'sd3, -6'sd2};
    run("mixed", 1, 5, 1);
    logits = '{0, 0, 0, 7, 0, 0, 0, 0, 7, 0};
    run("tie", 3, 7, 0);
    for (int i = 0; i < 10; i++) logits[i] = -6'sd32;
    run("allmin", 0, -32, 0);
    logits[9] = 6'sd31;
    run("extreme", 9, 31, 63);
    // Re-raise: class_valid clears on the accept edge.
    @(negedge clk);
    start = 1;
    @(negedge clk);
    check("accept valid", class_valid, 0);
    check("accept busy", busy, 1);
    repeat (4) @(negedge clk);
    check("mid addr", logit_addr, 4);
    #2 rst_n = 0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort valid", class_valid, 0);
    check("abort idx", class_idx, 0);
    check("abort addr", logit_addr, 0);
    check("abort margin", margin, 0);
    start = 0;
    @(negedge clk);
    rst_n = 1;
    logits = '{-6'sd3, 6'sd5, 6'sd1, -6'sd32, 6'sd2, 6'sd0, 6'sd4, -6'sd1, 6'sd3, -6'sd2};
    logits[6] = 6'sd20;
    run("fresh", 6, 20, 15);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
